// File: rtl/fadd_cal_pipe.sv
// fadd_cal_pipe: two-stage fraction add/subtract returning magnitude, sign flip,
// zero flag and leading-zero count over a valid/ready handshake.
module fadd_cal_pipe #(
   parameter int FRAC_W = 24,
   parameter int GRS_W = 3,
   localparam int SM_W = FRAC_W + GRS_W,
   localparam int SUM_W = SM_W + 1,
   localparam int LZ_W = $clog2(SUM_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              op_sub,
   input  logic [FRAC_W-1:0] large_frac,
   input  logic [SM_W-1:0]   small_frac,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SUM_W-1:0]  cal_frac,
   output logic              neg,
   output logic              zero,
   output logic [LZ_W-1:0]   lzc
);
   logic             s1_valid, s1_neg, s1_adv, s2_adv, b_gt;
   logic [SUM_W-1:0] a, b, r, s1_r;
   logic [LZ_W-1:0]  lz;

   assign s2_adv = !out_valid || out_ready;
   assign s1_adv = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // Compare and subtract together so only a magnitude is ever registered
   always_comb begin
      a = {1'b0, large_frac, {GRS_W{1'b0}}};
      b = {1'b0, small_frac};
      b_gt = b > a;
      r = !op_sub ? a + b : b_gt ? b - a : a - b;
   end

   always_comb begin
      lz = LZ_W'(SUM_W);
      for (int i = 0; i < SUM_W; i++)
         if (s1_r[i]) lz = LZ_W'(SUM_W - 1 - i);
   end

   always_ff @(posedge clk)
      if (in_valid && s1_adv) begin
         s1_r <= r;
         s1_neg <= op_sub && b_gt;
      end

   always_ff @(posedge clk)
      if (rst) begin
         s1_valid <= 1'b0;
         out_valid <= 1'b0;
         cal_frac <= '0;
         neg <= 1'b0;
         zero <= 1'b0;
         lzc <= '0;
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (s2_adv) out_valid <= s1_valid;
         if (s2_adv && s1_valid) begin
            cal_frac <= s1_r;
            neg <= s1_neg && |s1_r;
            zero <= ~|s1_r;
            lzc <= lz;
         end
      end
endmodule

// File: tb/tb_fadd_cal_pipe.sv
// tb_fadd_cal_pipe: directed and randomized checks of fadd_cal_pipe against an
// arithmetic reference model with a queue of expected results.
module tb_fadd_cal_pipe;
   logic        clk = 0, rst = 1, in_valid = 0, in_ready, op_sub = 0;
   logic [23:0] large_frac = 0;
   logic [26:0] small_frac = 0;
   logic        out_valid, out_ready = 1, neg, zero;
   logic [27:0] cal_frac;
   logic [4:0]  lzc;
   int          checks = 0, errors = 0;

   typedef struct {
      logic [27:0] f;
      logic        n, z;
      logic [4:0]  l;
   } exp_t;
   exp_t q[$];

   fadd_cal_pipe #(.FRAC_W(24), .GRS_W(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
      .large_frac(large_frac), .small_frac(small_frac), .out_valid(out_valid),
      .out_ready(out_ready), .cal_frac(cal_frac), .neg(neg), .zero(zero), .lzc(lzc)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(logic sub, logic [23:0] l, logic [26:0] s);
      longint av, bv, rv;
      exp_t   e;
      av = longint'(l) * 8;
      bv = longint'(s);
      e.n = sub && bv > av;
      rv = !sub ? av + bv : e.n ? bv - av : av - bv;
      e.f = rv[27:0];
      e.z = rv == 0;
      e.l = 5'd28;
      for (longint v = rv; v > 0; v = v >> 1) e.l--;
      return e;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Called at a negedge with inputs driven; scores this edge's transfers, then advances one cycle
   task automatic tick();
      exp_t e;
      #1;
      if (!rst && out_valid && out_ready) begin
         chk("spurious_out", q.size() > 0, 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("cal_frac", cal_frac, e.f);
            chk("neg", neg, e.n);
            chk("zero", zero, e.z);
            chk("lzc", lzc, e.l);
         end
      end
      if (!rst && in_valid && in_ready) q.push_back(model(op_sub, large_frac, small_frac));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic garbage();
      in_valid = 0;
      op_sub = 1'($urandom);
      large_frac = 24'($urandom);
      small_frac = 27'($urandom);
   endtask

   task automatic send1(string tag, logic sub, logic [23:0] l, logic [26:0] s,
                        logic [27:0] f, logic n, logic z, logic [4:0] lz);
      in_valid = 1; op_sub = sub; large_frac = l; small_frac = s; out_ready = 1;
      #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      tick();
      garbage();
      chk({tag, "_lat1"}, out_valid, 0);
      tick();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_frac"}, cal_frac, f);
      chk({tag, "_neg"}, neg, n);
      chk({tag, "_zero"}, zero, z);
      chk({tag, "_lzc"}, lzc, lz);
      tick();
   endtask

   task automatic drain();
      garbage();
      out_ready = 1;
      for (int i = 0; i < 20 && (q.size() > 0 || out_valid); i++) tick();
      chk("drain_empty", q.size(), 0);
      chk("drain_valid", out_valid, 0);
   endtask

   initial begin
      int sent, cyc;
      logic stalled;
      @(negedge clk);
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_frac", cal_frac, 0);
      chk("rst_neg", neg, 0);
      chk("rst_zero", zero, 0);
      chk("rst_lzc", lzc, 0);
      rst = 0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_valid", out_valid, 0);

      send1("t1_add", 0, 24'h800000, 27'h4000000, 28'h8000000, 0, 0, 5'd0);
      send1("t2_sub", 1, 24'hC00000, 27'h2000000, 28'h4000000, 0, 0, 5'd1);
      send1("t3_neg", 1, 24'h800000, 27'h5000000, 28'h1000000, 1, 0, 5'd3);
      send1("t4_zero", 1, 24'h800000, 27'h4000000, 28'h0, 0, 1, 5'd28);
      send1("zero_add", 0, 24'h0, 27'h0, 28'h0, 0, 1, 5'd28);
      send1("zero_sub", 1, 24'h0, 27'h0, 28'h0, 0, 1, 5'd28);
      send1("max_add", 0, 24'hFFFFFF, 27'h7FFFFFF, 28'hFFFFFF7, 0, 0, 5'd0);

      sent = 0; cyc = 0; stalled = 0;
      while (sent < 8 && cyc < 50) begin
         in_valid = 1; op_sub = 1'($urandom);
         large_frac = 24'($urandom); small_frac = 27'($urandom);
         out_ready = !(cyc >= 2 && cyc < 5);
         #1;
         if (!in_ready) stalled = 1;
         if (in_ready) sent++;
         tick();
         cyc++;
      end
      chk("t5_sent8", sent, 8);
      chk("t5_stall_seen", stalled, 1);
      drain();

      for (int i = 0; i < 2; i++) begin
         in_valid = 1; op_sub = 0; large_frac = 24'($urandom); small_frac = 27'($urandom);
         tick();
      end
      garbage();
      rst = 1;
      tick();
      rst = 0;
      q.delete();
      chk("t6_valid_after_rst", out_valid, 0);
      chk("t6_frac_after_rst", cal_frac, 0);
      send1("t6_after", 1, 24'hC00000, 27'h2000000, 28'h4000000, 0, 0, 5'd1);
      chk("t6_no_stale", out_valid, 0);

      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom % 4) != 0;
         op_sub = 1'($urandom);
         large_frac = 24'($urandom);
         small_frac = ($urandom % 6 == 0) ? {large_frac, 3'b000} : 27'($urandom);
         if ($urandom % 8 == 0) small_frac = small_frac >> ($urandom % 27);
         out_ready = ($urandom % 3) != 0;
         tick();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
